// File: rtl/link_fault_sm_param.sv
// Link-fault detector for the XGMII receive path: qualifies ||LF||/||RF|| ordered sets
// column by column and drives fault status, a change pulse and saturating event counters.
module link_fault_sm_param #(
    parameter int DATA_WIDTH = 64,
    parameter int COL_THRESH = 128,
    parameter int SEQ_THRESH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_xgmii_rx,
    input  logic                    reset_xgmii_rx,
    input  logic [DATA_WIDTH-1:0]   xgmii_rxd,
    input  logic [DATA_WIDTH/8-1:0] xgmii_rxc,
    input  logic                    fault_det_en,
    input  logic                    cnt_clr,
    output logic                    local_fault,
    output logic                    remote_fault,
    output logic                    fault_change,
    output logic [CNT_WIDTH-1:0]    lf_event_cnt,
    output logic [CNT_WIDTH-1:0]    rf_event_cnt
);
    localparam int NCOL = DATA_WIDTH / 32;
    localparam int CW   = $clog2(COL_THRESH + 1);
    localparam int SW   = $clog2(SEQ_THRESH + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_THRESH - 1);
    localparam logic [SW-1:0] SEQ_LAST = SW'(SEQ_THRESH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                r_state, w_state;
    logic [SW-1:0]         r_seq_cnt, w_seq_cnt;
    logic [CW-1:0]         r_col_cnt, w_col_cnt;
    logic                  r_last_rf, w_last_rf;
    logic                  r_local, r_remote, w_local, w_remote;
    logic                  w_en_local, w_en_remote;
    logic                  r_change;
    logic [CNT_WIDTH-1:0]  r_lf_cnt, r_rf_cnt;
    logic [NCOL-1:0]       w_col_fault, w_col_rf;

    // Classify each 32-bit column as LF, RF or non-fault
    always_comb begin
        w_col_fault = '0;
        w_col_rf    = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (xgmii_rxc[4*c +: 4] == 4'b0001 && xgmii_rxd[32*c +: 8] == 8'h9C &&
                xgmii_rxd[32*c+8 +: 16] == 16'h0000 &&
                (xgmii_rxd[32*c+24 +: 8] == 8'h01 || xgmii_rxd[32*c+24 +: 8] == 8'h02)) begin
                w_col_fault[c] = 1'b1;
                w_col_rf[c]    = (xgmii_rxd[32*c+24 +: 8] == 8'h02);
            end else begin
                w_col_fault[c] = 1'b0;
                w_col_rf[c]    = 1'b0;
            end
        end
    end

    // Walk the columns in ascending order; in FAULT the active type is held in w_remote
    always_comb begin
        w_state   = r_state;
        w_seq_cnt = r_seq_cnt;
        w_col_cnt = r_col_cnt;
        w_last_rf = r_last_rf;
        w_local   = r_local;
        w_remote  = r_remote;
        for (int c = 0; c < NCOL; c++) begin
            case (w_state)
                IDLE: begin
                    if (w_col_fault[c]) begin
                        w_last_rf = w_col_rf[c];
                        w_seq_cnt = SW'(1);
                        w_col_cnt = '0;
                        w_state   = COUNT;
                    end else begin
                        w_state   = IDLE;
                    end
                end
                COUNT, FAULT: begin
                    if (w_col_fault[c]) begin
                        w_col_cnt = '0;
                        if (w_state == FAULT && w_col_rf[c] == w_remote) begin
                            w_seq_cnt = '0;
                        end else if (w_col_rf[c] != w_last_rf) begin
                            w_last_rf = w_col_rf[c];
                            w_seq_cnt = SW'(1);
                        end else if (w_seq_cnt == SEQ_LAST) begin
                            w_state   = FAULT;
                            w_local   = ~w_col_rf[c];
                            w_remote  = w_col_rf[c];
                            w_seq_cnt = '0;
                        end else begin
                            w_seq_cnt = w_seq_cnt + SW'(1);
                        end
                    end else if (w_col_cnt == COL_LAST) begin
                        w_state   = IDLE;
                        w_seq_cnt = '0;
                        w_col_cnt = '0;
                        w_local   = 1'b0;
                        w_remote  = 1'b0;
                    end else begin
                        w_col_cnt = w_col_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state   = IDLE;
                    w_seq_cnt = '0;
                    w_col_cnt = '0;
                    w_local   = 1'b0;
                    w_remote  = 1'b0;
                end
            endcase
        end
    end

    assign w_en_local  = fault_det_en & w_local;
    assign w_en_remote = fault_det_en & w_remote;

    // Qualification state register; disabling the detector discards all progress
    always_ff @(posedge clk_xgmii_rx) begin
        if (reset_xgmii_rx) begin
            r_state   <= IDLE;
            r_seq_cnt <= '0;
            r_col_cnt <= '0;
            r_last_rf <= 1'b0;
        end else if (!fault_det_en) begin
            r_state   <= IDLE;
            r_seq_cnt <= '0;
            r_col_cnt <= '0;
            r_last_rf <= r_last_rf;
        end else begin
            r_state   <= w_state;
            r_seq_cnt <= w_seq_cnt;
            r_col_cnt <= w_col_cnt;
            r_last_rf <= w_last_rf;
        end
    end

    // Fault status and its change pulse
    always_ff @(posedge clk_xgmii_rx) begin
        if (reset_xgmii_rx) begin
            r_local  <= 1'b0;
            r_remote <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_local  <= w_en_local;
            r_remote <= w_en_remote;
            r_change <= (w_en_local != r_local) || (w_en_remote != r_remote);
        end
    end

    // Saturating entry counters; a clear beats a same-cycle entry
    always_ff @(posedge clk_xgmii_rx) begin
        if (reset_xgmii_rx || cnt_clr) begin
            r_lf_cnt <= '0;
            r_rf_cnt <= '0;
        end else begin
            if (w_en_local && !r_local && r_lf_cnt != {CNT_WIDTH{1'b1}}) begin
                r_lf_cnt <= r_lf_cnt + CNT_WIDTH'(1);
            end else begin
                r_lf_cnt <= r_lf_cnt;
            end
            if (w_en_remote && !r_remote && r_rf_cnt != {CNT_WIDTH{1'b1}}) begin
                r_rf_cnt <= r_rf_cnt + CNT_WIDTH'(1);
            end else begin
                r_rf_cnt <= r_rf_cnt;
            end
        end
    end

    assign local_fault  = r_local;
    assign remote_fault = r_remote;
    assign fault_change = r_change;
    assign lf_event_cnt = r_lf_cnt;
    assign rf_event_cnt = r_rf_cnt;
endmodule

// File: tb/tb_link_fault_sm_param.sv
// Bench for link_fault_sm_param: a 64-bit default instance and a 32-bit instance with
// small thresholds, both checked every cycle against a behavioural model plus directed checks.
module tb_link_fault_sm_param;
    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [63:0] rxd_a;
    logic [7:0]  rxc_a;
    logic [31:0] rxd_b;
    logic [3:0]  rxc_b;
    logic        local_a, remote_a, change_a, local_b, remote_b, change_b;
    logic [15:0] lf_a, rf_a;
    logic [1:0]  lf_b, rf_b;

    int n_vec = 0;
    int n_err = 0;

    // model state per instance: status 0 none / 1 LF / 2 RF
    int m_active[2], m_status[2], m_cand[2], m_run[2], m_gap[2], m_chg[2], m_lfc[2], m_rfc[2];

    always #5 clk = ~clk;

    link_fault_sm_param u_a (
        .clk_xgmii_rx(clk), .reset_xgmii_rx(rst), .xgmii_rxd(rxd_a), .xgmii_rxc(rxc_a),
        .fault_det_en(en), .cnt_clr(clr), .local_fault(local_a), .remote_fault(remote_a),
        .fault_change(change_a), .lf_event_cnt(lf_a), .rf_event_cnt(rf_a)
    );

    link_fault_sm_param #(.DATA_WIDTH(32), .COL_THRESH(6), .SEQ_THRESH(3), .CNT_WIDTH(2)) u_b (
        .clk_xgmii_rx(clk), .reset_xgmii_rx(rst), .xgmii_rxd(rxd_b), .xgmii_rxc(rxc_b),
        .fault_det_en(en), .cnt_clr(clr), .local_fault(local_b), .remote_fault(remote_b),
        .fault_change(change_b), .lf_event_cnt(lf_b), .rf_event_cnt(rf_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int col_type(input logic [31:0] d, input logic [3:0] c);
        if (c != 4'b0001 || d[7:0] != 8'h9C || d[23:8] != 16'h0000) return 0;
        if (d[31:24] == 8'h01) return 1;
        if (d[31:24] == 8'h02) return 2;
        return 0;
    endfunction

    task automatic model_step(input int k, input logic [63:0] d, input logic [7:0] c);
        int prev, t, ncol, colth, seqth, cmax;
        ncol  = (k == 0) ? 2 : 1;
        colth = (k == 0) ? 128 : 6;
        seqth = (k == 0) ? 4 : 3;
        cmax  = (k == 0) ? 65535 : 3;
        if (rst) begin
            m_active[k] = 0; m_status[k] = 0; m_cand[k] = 1; m_run[k] = 0;
            m_gap[k] = 0; m_chg[k] = 0; m_lfc[k] = 0; m_rfc[k] = 0;
            return;
        end
        prev = m_status[k];
        for (int i = 0; i < ncol; i++) begin
            t = col_type(d[32*i +: 32], c[4*i +: 4]);
            if (t != 0) begin
                m_gap[k] = 0;
                if (m_active[k] == 0) begin
                    m_active[k] = 1; m_cand[k] = t; m_run[k] = 1;
                end else if (t == m_status[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]  = (t == m_cand[k]) ? m_run[k] + 1 : 1;
                    m_cand[k] = t;
                    if (m_run[k] == seqth) begin
                        m_status[k] = t; m_run[k] = 0;
                    end
                end
            end else if (m_active[k] != 0) begin
                m_gap[k]++;
                if (m_gap[k] == colth) begin
                    m_active[k] = 0; m_status[k] = 0; m_run[k] = 0; m_gap[k] = 0;
                end
            end
        end
        if (!en) begin
            m_active[k] = 0; m_status[k] = 0; m_run[k] = 0; m_gap[k] = 0;
        end
        m_chg[k] = (m_status[k] != prev) ? 1 : 0;
        if (clr) begin
            m_lfc[k] = 0; m_rfc[k] = 0;
        end else if (m_status[k] != prev) begin
            if (m_status[k] == 1 && m_lfc[k] < cmax) m_lfc[k]++;
            if (m_status[k] == 2 && m_rfc[k] < cmax) m_rfc[k]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, rxd_a, rxc_a);
        model_step(1, {32'h0, rxd_b}, {4'h0, rxc_b});
        #1;
        check_val("A.local",  32'(local_a),  32'(m_status[0] == 1));
        check_val("A.remote", 32'(remote_a), 32'(m_status[0] == 2));
        check_val("A.change", 32'(change_a), 32'(m_chg[0]));
        check_val("A.lf_cnt", 32'(lf_a),     32'(m_lfc[0]));
        check_val("A.rf_cnt", 32'(rf_a),     32'(m_rfc[0]));
        check_val("B.local",  32'(local_b),  32'(m_status[1] == 1));
        check_val("B.remote", 32'(remote_b), 32'(m_status[1] == 2));
        check_val("B.change", 32'(change_b), 32'(m_chg[1]));
        check_val("B.lf_cnt", 32'(lf_b),     32'(m_lfc[1]));
        check_val("B.rf_cnt", 32'(rf_b),     32'(m_rfc[1]));
    endtask

    // kinds: 0 idle, 1 LF, 2 RF, 3 random, 4 other sequence code, 5 extra control bit
    function automatic logic [35:0] gen_col(input int kind);
        logic [35:0] r;
        case (kind)
            1:       r = {4'h1, 32'h0100_009C};
            2:       r = {4'h1, 32'h0200_009C};
            3:       r = {4'($urandom), 32'($urandom)};
            4:       r = {4'h1, 8'($urandom_range(3, 255)), 24'h00_009C};
            5:       r = {4'h3, 32'h0100_009C};
            default: r = {4'hF, 32'h0707_0707};
        endcase
        return r;
    endfunction

    function automatic int rnd_kind(input int mode);
        int r;
        r = $urandom_range(0, 99);
        if (mode == 1) return (r < 97) ? 0 : ((r < 98) ? 1 : 2);
        if (mode == 2) return (r < 50) ? 0 : ((r < 85) ? 1 : 2);
        if (r < 40) return 0;
        if (r < 60) return 1;
        if (r < 80) return 2;
        return $urandom_range(3, 5);
    endfunction

    task automatic set_a(input int k0, input int k1);
        logic [35:0] c0, c1;
        c0 = gen_col(k0);
        c1 = gen_col(k1);
        rxd_a = {c1[31:0], c0[31:0]};
        rxc_a = {c1[35:32], c0[35:32]};
    endtask

    task automatic set_b(input int k0);
        logic [35:0] c0;
        c0 = gen_col(k0);
        rxd_b = c0[31:0];
        rxc_b = c0[35:32];
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        set_a(0, 0); set_b(0);
        step(); step();
        check_val("rst_local", 32'(local_a), 32'd0);
        check_val("rst_lfcnt", 32'(lf_a), 32'd0);
        rst = 1'b0;

        // LF in col0 of four words, 60 columns apart
        for (int w = 0; w < 4; w++) begin
            set_a(1, 0); step();
            if (w < 3) begin
                set_a(0, 0); repeat (29) step();
            end
        end
        check_val("lf4_local", 32'(local_a), 32'd1);
        check_val("lf4_change", 32'(change_a), 32'd1);
        check_val("lf4_cnt", 32'(lf_a), 32'd1);

        // 127 idle columns keep the fault, the 128th clears it
        set_a(0, 0); repeat (63) step();
        check_val("hold127_local", 32'(local_a), 32'd1);
        check_val("hold127_change", 32'(change_a), 32'd0);
        step();
        check_val("clr128_local", 32'(local_a), 32'd0);
        check_val("clr128_change", 32'(change_a), 32'd1);

        // alternating LF/RF never qualifies
        for (int i = 0; i < 8; i++) begin
            set_a((i % 2 == 0) ? 1 : 2, 0); step();
            set_a(0, 0); step();
        end
        check_val("alt_local", 32'(local_a), 32'd0);
        check_val("alt_remote", 32'(remote_a), 32'd0);
        set_a(0, 0); repeat (64) step();

        // 3 LF, exactly 128 idle columns, then LF restarts the count
        set_a(1, 0); repeat (3) step();
        set_a(0, 0); repeat (63) step();
        set_a(0, 1); step();
        check_val("gap_local", 32'(local_a), 32'd0);
        set_a(1, 0); repeat (2) step();
        check_val("gap_seq3_local", 32'(local_a), 32'd0);
        set_a(0, 0); repeat (64) step();

        // LF in both columns, two words
        set_a(1, 1); step();
        check_val("dbl1_local", 32'(local_a), 32'd0);
        step();
        check_val("dbl2_local", 32'(local_a), 32'd1);
        check_val("dbl2_cnt", 32'(lf_a), 32'd2);

        // switch LF -> RF with four RF sequences
        set_a(2, 0); repeat (3) step();
        check_val("rf3_local", 32'(local_a), 32'd1);
        check_val("rf3_remote", 32'(remote_a), 32'd0);
        step();
        check_val("rf4_remote", 32'(remote_a), 32'd1);
        check_val("rf4_local", 32'(local_a), 32'd0);
        check_val("rf4_change", 32'(change_a), 32'd1);
        check_val("rf4_cnt", 32'(rf_a), 32'd1);

        // disable drops status and pulses change; counters hold
        en = 1'b0; set_a(2, 2); step();
        check_val("dis_remote", 32'(remote_a), 32'd0);
        check_val("dis_change", 32'(change_a), 32'd1);
        check_val("dis_rfcnt", 32'(rf_a), 32'd1);
        en = 1'b1; set_a(0, 0); step();
        check_val("en_change", 32'(change_a), 32'd0);
        clr = 1'b1; step(); clr = 1'b0;
        check_val("clr_lf", 32'(lf_a), 32'd0);
        check_val("clr_rf", 32'(rf_a), 32'd0);

        // 32-bit instance: five LF entries saturate a 2-bit counter
        for (int e = 1; e <= 5; e++) begin
            set_b(1); repeat (3) step();
            check_val("b_entry_cnt", 32'(lf_b), (e > 3) ? 32'd3 : 32'(e));
            set_b(0); repeat (6) step();
        end
        check_val("b_exit_local", 32'(local_b), 32'd0);

        // clear coincident with an entry
        set_b(1); repeat (2) step();
        clr = 1'b1; step(); clr = 1'b0;
        check_val("b_clr_local", 32'(local_b), 32'd1);
        check_val("b_clr_cnt", 32'(lf_b), 32'd0);
        set_b(0); repeat (6) step();

        // reset mid-qualification discards progress
        set_b(1); repeat (2) step();
        rst = 1'b1; step(); rst = 1'b0;
        check_val("b_rst_change", 32'(change_b), 32'd0);
        repeat (2) step();
        check_val("b_rst_local", 32'(local_b), 32'd0);
        set_b(0); repeat (6) step();

        // randomized segments of differing fault density
        for (int seg = 0; seg < 12; seg++) begin
            int mode;
            mode = $urandom_range(0, 2);
            repeat (150) begin
                set_a(rnd_kind(mode), rnd_kind(mode));
                set_b(rnd_kind(mode));
                rst = ($urandom_range(0, 499) == 0);
                en  = ($urandom_range(0, 99) != 0);
                clr = ($urandom_range(0, 49) == 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
